// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 stride-2 pooling unit.
//   POOL_MAX / POOL_AVG : encodings of the runtime mode input
//   cnt_w()             : counter/address width for a count of n (at least 1 bit)
//   pool_max()          : larger of two pre-extended operands, signed or unsigned
package pool_pkg;

    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;

    // Operands are extended to this width before compare, so one function
    // serves every pixel width up to MAX_W-2 bits.
    localparam int MAX_W = 64;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [MAX_W-1:0] pool_max(input logic [MAX_W-1:0] a,
                                                  input logic [MAX_W-1:0] b,
                                                  input logic             is_signed);
        if (is_signed)
            return ($signed(a) > $signed(b)) ? a : b;
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer holding one horizontal pair result per output column.
//   i_we / i_waddr / i_wdata : write port, used on even rows
//   i_re / i_raddr           : read request, used on odd-row even-column beats
//   o_rdata                  : registered read data, held until the next read
// Contents are not reset; every entry is written before it is read.
module pool_line_buf
    import pool_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        if (i_re)
            o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/pool2x2_stream.sv
// 2x2 stride-2 max/average pooling over a raster-order pixel stream.
//   clk, rst_n    : clock, synchronous active-low reset
//   mode          : 0 = max, 1 = average; latched on the first pixel of a frame
//   frame_start   : abandons any partial frame; a same-cycle pixel becomes (0,0)
//   data_in       : pixel, accepted when in_valid is high (always ready)
//   data_out      : pooled pixel, held between pulses
//   out_valid     : one-cycle pulse per pooled pixel, one cycle after the beat
//   frame_done    : pulses with the last out_valid of a frame
module pool2x2_stream
    import pool_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              frame_start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              frame_done
);

    localparam int PW    = DATA_W + 1;
    localparam int SW    = DATA_W + 2;
    localparam int DEPTH = IMG_W / 2;
    localparam int AW    = cnt_w(DEPTH);
    localparam int CW_W  = cnt_w(IMG_W);
    localparam int RW_W  = cnt_w(IMG_H);

    localparam logic [CW_W-1:0] COL_LAST = CW_W'(IMG_W - 1);
    localparam logic [RW_W-1:0] ROW_LAST = RW_W'(IMG_H - 1);
    localparam logic [CW_W-1:0] COL_END  = CW_W'(2 * (IMG_W / 2) - 1);
    localparam logic [RW_W-1:0] ROW_END  = RW_W'(2 * (IMG_H / 2) - 1);
    localparam logic            SGN      = (SIGNED != 0);

    function automatic logic [MAX_W-1:0] ext_d(input logic [DATA_W-1:0] x);
        return {{(MAX_W-DATA_W){SGN & x[DATA_W-1]}}, x};
    endfunction

    function automatic logic [MAX_W-1:0] ext_p(input logic [PW-1:0] x);
        return {{(MAX_W-PW){SGN & x[PW-1]}}, x};
    endfunction

    logic [CW_W-1:0]   r_col;
    logic [RW_W-1:0]   r_row;
    logic [DATA_W-1:0] r_h;
    logic              r_mode;
    logic [DATA_W-1:0] r_do;
    logic              r_ov;
    logic              r_fd;

    logic [CW_W-1:0]   w_col;
    logic [RW_W-1:0]   w_row;
    logic              w_col_ok;
    logic              w_row_ok;
    logic              w_re;
    logic              w_we;
    logic              w_fire;
    logic              w_last;
    logic [AW-1:0]     w_addr;
    logic [PW-1:0]     w_pair;
    logic [PW-1:0]     w_buf;
    logic [SW-1:0]     w_rsum;
    logic [DATA_W-1:0] w_res;

    // frame_start restarts the position immediately so a same-cycle beat is (0,0)
    assign w_col = frame_start ? '0 : r_col;
    assign w_row = frame_start ? '0 : r_row;

    // The trailing column/row of an odd dimension is counted but never pooled
    assign w_col_ok = ((IMG_W % 2) == 0) || (w_col != COL_LAST);
    assign w_row_ok = ((IMG_H % 2) == 0) || (w_row != ROW_LAST);

    assign w_re   = in_valid & ~w_col[0] & w_col_ok & w_row[0];
    assign w_we   = in_valid &  w_col[0] & w_row_ok & ~w_row[0];
    assign w_fire = in_valid &  w_col[0] & w_row_ok &  w_row[0];
    assign w_last = w_fire && (w_row == ROW_END) && (w_col == COL_END);
    assign w_addr = AW'(w_col >> 1);

    pool_line_buf #(
        .WIDTH (PW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_line_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_addr),
        .i_wdata (w_pair),
        .i_re    (w_re),
        .i_raddr (w_addr),
        .o_rdata (w_buf)
    );

    // Horizontal pair, then vertical combine with the buffered pair.
    // The 4-pixel average always fits in DATA_W bits, so dropping the two
    // low bits of the DATA_W+2-bit sum is the floor divide in both signednesses.
    always_comb begin
        w_pair = '0;
        w_res  = '0;
        w_rsum = SW'(ext_p(w_buf)) + SW'(ext_p(w_pair));
        if (r_mode == POOL_AVG)
            w_pair = PW'(ext_d(r_h)) + PW'(ext_d(data_in));
        else
            w_pair = PW'(pool_max(ext_d(r_h), ext_d(data_in), SGN));
        w_rsum = SW'(ext_p(w_buf)) + SW'(ext_p(w_pair));
        if (r_mode == POOL_AVG)
            w_res = DATA_W'(w_rsum >> 2);
        else
            w_res = DATA_W'(pool_max(ext_p(w_buf), ext_p(w_pair), SGN));
    end

    // Position counters, holding register and mode latch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col  <= '0;
            r_row  <= '0;
            r_h    <= '0;
            r_mode <= POOL_MAX;
        end else if (in_valid) begin
            if (w_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
            if (!w_col[0])
                r_h <= data_in;
            if ((w_col == '0) && (w_row == '0))
                r_mode <= mode;
        end else if (frame_start) begin
            r_col <= '0;
            r_row <= '0;
            r_h   <= '0;
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_do <= '0;
            r_ov <= 1'b0;
            r_fd <= 1'b0;
        end else begin
            r_ov <= w_fire;
            r_fd <= w_last;
            if (w_fire)
                r_do <= w_res;
        end
    end

    assign data_out   = r_do;
    assign out_valid  = r_ov;
    assign frame_done = r_fd;

endmodule

// File: tb/tb_pool2x2_stream.sv
module tb_pool2x2_stream;

    localparam logic M_MAX = 1'b0;
    localparam logic M_AVG = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic        frame_start;
    logic [15:0] data_in;
    logic        in_valid;

    logic [15:0] dout [4];
    logic        ov   [4];
    logic        fd   [4];

    int          sel;
    logic [15:0] m_do;
    logic        m_ov;
    logic        m_fd;

    longint      cyc = 0;
    int          n_assert = 0;
    int          n_fail   = 0;

    int          pix  [1024];
    longint      bcyc [1024];

    logic [15:0] q_d  [$];
    logic        q_fd [$];
    longint      q_cy [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pool2x2_stream #(.DATA_W(16), .IMG_W(4), .IMG_H(4), .SIGNED(0)) u_a (
        .clk(clk), .rst_n(rst_n), .mode(mode), .frame_start(frame_start),
        .data_in(data_in), .in_valid(in_valid),
        .data_out(dout[0]), .out_valid(ov[0]), .frame_done(fd[0]));

    pool2x2_stream #(.DATA_W(16), .IMG_W(4), .IMG_H(4), .SIGNED(1)) u_b (
        .clk(clk), .rst_n(rst_n), .mode(mode), .frame_start(frame_start),
        .data_in(data_in), .in_valid(in_valid),
        .data_out(dout[1]), .out_valid(ov[1]), .frame_done(fd[1]));

    pool2x2_stream #(.DATA_W(16), .IMG_W(5), .IMG_H(3), .SIGNED(0)) u_c (
        .clk(clk), .rst_n(rst_n), .mode(mode), .frame_start(frame_start),
        .data_in(data_in), .in_valid(in_valid),
        .data_out(dout[2]), .out_valid(ov[2]), .frame_done(fd[2]));

    pool2x2_stream #(.DATA_W(16), .IMG_W(32), .IMG_H(32), .SIGNED(1)) u_d (
        .clk(clk), .rst_n(rst_n), .mode(mode), .frame_start(frame_start),
        .data_in(data_in), .in_valid(in_valid),
        .data_out(dout[3]), .out_valid(ov[3]), .frame_done(fd[3]));

    always_comb begin
        m_do = dout[sel];
        m_ov = ov[sel];
        m_fd = fd[sel];
    end

    always @(negedge clk) begin
        if (m_ov === 1'b1) begin
            q_d.push_back(m_do);
            q_fd.push_back(m_fd);
            q_cy.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sx(input int v, input bit sg);
        int u;
        u = v & 32'hFFFF;
        if (sg && u >= 32768)
            return u - 65536;
        return u;
    endfunction

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++)
            pix[i] = int'($urandom & 32'hFFFF);
    endtask

    // Present n pixels of pix[]; mode is flipped after the first beat to
    // show it is only taken at the start of a frame.
    task automatic drive(input int n, input bit fs, input logic md, input int maxgap);
        int g;
        for (int i = 0; i < n; i++) begin
            data_in     = pix[i][15:0];
            in_valid    = 1'b1;
            frame_start = fs && (i == 0);
            mode        = (i == 0) ? md : ~md;
            bcyc[i]     = cyc;
            tick();
            in_valid    = 1'b0;
            frame_start = 1'b0;
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            repeat (g) tick();
        end
    endtask

    task automatic check_frame(input string ph, input int w, input int h,
                               input bit sg, input logic md);
        int k, a, b, c, d, e, s, tl;
        k = 0;
        chk({ph, "_count"}, q_d.size(), (w / 2) * (h / 2));
        for (int r = 0; r < h / 2; r++) begin
            for (int cc = 0; cc < w / 2; cc++) begin
                tl = 2 * r * w + 2 * cc;
                a = sx(pix[tl], sg);
                b = sx(pix[tl + 1], sg);
                c = sx(pix[tl + w], sg);
                d = sx(pix[tl + w + 1], sg);
                if (md == M_MAX) begin
                    e = a;
                    if (b > e) e = b;
                    if (c > e) e = c;
                    if (d > e) e = d;
                end else begin
                    s = a + b + c + d;
                    e = s / 4;
                    if (s < 0 && (s % 4) != 0) e = e - 1;
                end
                if (k < q_d.size()) begin
                    chk($sformatf("%s_data[%0d]", ph, k), q_d[k], e & 32'hFFFF);
                    chk($sformatf("%s_done[%0d]", ph, k), q_fd[k],
                        (r == h / 2 - 1 && cc == w / 2 - 1) ? 1 : 0);
                    chk($sformatf("%s_lat[%0d]", ph, k), q_cy[k],
                        bcyc[(2 * r + 1) * w + 2 * cc + 1] + 1);
                end
                k++;
            end
        end
    endtask

    task automatic run_frame(input string ph, input int s, input int w, input int h,
                             input bit sg, input logic md, input bit fs, input int maxgap);
        sel = s;
        q_d.delete();
        q_fd.delete();
        q_cy.delete();
        drive(w * h, fs, md, maxgap);
        repeat (3) tick();
        check_frame(ph, w, h, sg, md);
    endtask

    initial begin
        rst_n       = 1'b0;
        mode        = M_MAX;
        frame_start = 1'b0;
        data_in     = '0;
        in_valid    = 1'b0;
        sel         = 0;
        repeat (2) tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_ov%0d", k), ov[k], 0);
            chk($sformatf("rst_do%0d", k), dout[k], 0);
            chk($sformatf("rst_fd%0d", k), fd[k], 0);
        end
        rst_n = 1'b1;
        tick();

        // 4x4 unsigned max, ramp 0..15
        for (int i = 0; i < 16; i++) pix[i] = i;
        run_frame("A", 0, 4, 4, 0, M_MAX, 1, 0);
        if (q_d.size() == 4) begin
            chk("A_lit0", q_d[0], 5);
            chk("A_lit3", q_d[3], 15);
        end

        // 4x4 signed average with negative top-left window
        pix[0]  = -4; pix[1]  = -3; pix[2]  = 10; pix[3]  = 11;
        pix[4]  = -2; pix[5]  = -1; pix[6]  = 12; pix[7]  = 14;
        pix[8]  = 20; pix[9]  = 21; pix[10] = 30; pix[11] = 31;
        pix[12] = 22; pix[13] = 24; pix[14] = 32; pix[15] = 35;
        run_frame("B", 1, 4, 4, 1, M_AVG, 1, 0);
        if (q_d.size() > 0)
            chk("B_lit0", q_d[0], 16'hFFFD);

        // 5x3: odd width and height, then a second frame with no resync
        for (int i = 0; i < 15; i++) pix[i] = i;
        run_frame("C1", 2, 5, 3, 0, M_MAX, 1, 0);
        if (q_d.size() == 2) begin
            chk("C1_lit0", q_d[0], 6);
            chk("C1_lit1", q_d[1], 8);
        end
        fill_random(15);
        run_frame("C2", 2, 5, 3, 0, M_AVG, 0, 2);

        // 32x32 random frames, with and without input gaps
        fill_random(1024);
        run_frame("D1", 3, 32, 32, 1, M_AVG, 1, 5);
        fill_random(1024);
        run_frame("D2", 3, 32, 32, 1, M_MAX, 1, 0);

        // Abandon a frame after 37 pixels, then a clean 4x4 frame in the other mode
        sel = 0;
        fill_random(37);
        drive(37, 1, M_AVG, 0);
        repeat (3) tick();
        fill_random(16);
        run_frame("E", 0, 4, 4, 0, M_MAX, 1, 0);

        // Reset coinciding with a window-completing beat in an odd row
        sel = 1;
        fill_random(16);
        drive(13, 1, M_AVG, 0);
        data_in  = pix[13][15:0];
        in_valid = 1'b1;
        rst_n    = 1'b0;
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        chk("F_rst_ov", ov[1], 0);
        chk("F_rst_do", dout[1], 0);
        chk("F_rst_fd", fd[1], 0);
        fill_random(16);
        run_frame("F", 1, 4, 4, 1, M_AVG, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
